// File: rtl/gbuf_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : gbuf_dma_engine
// Purpose  : Moves a block of words between a global buffer and a pair of
//            valid/ready streams. dir=1 writes stream words into the buffer,
//            dir=0 reads buffer words out to the stream through a 2-entry
//            output FIFO that keeps one word per cycle flowing.
// Ports    : clk, rst                      - clock, sync active-high reset
//            cmd_valid/ready/dir/base/len  - command handshake
//            busy, done, err               - status (done/err are pulses)
//            mem_ce/we/addr/wdata/rdata    - buffer master, 1-cycle read
//            in_valid/ready/data           - write-direction stream
//            out_valid/ready/data          - read-direction stream
// Revision : 1.0 - initial release
// ============================================================================
module gbuf_dma_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [31:0]       cmd_base,
    input  logic [10:0]       cmd_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned c_AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The direction of an accepted command is held by the state itself
    // (WRITE vs READ), so no separate direction flop is kept.
    state_t            state_q, state_d;
    logic [c_AW-1:0]   base_q, base_d;
    logic [10:0]       len_q, len_d;
    logic [10:0]       idx_q, idx_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              inflight_q, inflight_d;

    logic [c_AW-1:0]   w_addr;
    logic              w_pop;
    logic              w_issue;
    logic              w_cmd_ok;
    logic              w_unused;

    assign w_unused  = ^cmd_base[31:c_AW];
    assign w_addr    = base_q + idx_q[c_AW-1:0];
    assign mem_addr  = {{(32-c_AW){1'b0}}, w_addr};
    assign mem_wdata = in_data;
    assign w_cmd_ok  = (cmd_len != 11'd0) && ({21'b0, cmd_len} <= DEPTH);

    // Read data arriving this cycle is treated as already in the FIFO, so
    // the head falls through from mem_rdata when nothing is stored. This
    // gives first data two cycles after accept and keeps 1 word/cycle.
    assign out_valid = (count_q != 2'd0) || inflight_q;
    assign out_data  = (count_q == 2'd0) ? mem_rdata : fifo_q[rd_ptr_q];
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        err_d      = err_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cmd_ready  = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        err        = 1'b0;
        in_ready   = 1'b0;
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        w_issue    = 1'b0;

        // Returning read data is always captured; pops advance the head.
        if (inflight_q) begin
            fifo_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, inflight_q} - {1'b0, w_pop};

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    base_d = cmd_base[c_AW-1:0];
                    len_d  = cmd_len;
                    idx_d  = 11'd0;
                    err_d  = !w_cmd_ok;
                    if (!w_cmd_ok) begin
                        state_d = S_DONE;
                    end else if (cmd_dir) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                in_ready = 1'b1;
                mem_ce   = in_valid;
                mem_we   = in_valid;
                if (in_valid) begin
                    idx_d = idx_q + 11'd1;
                    if (idx_q == (len_q - 11'd1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                // Stored + in-flight words, less this cycle's pop, must
                // leave room for one more in the 2-entry FIFO.
                if (({1'b0, count_q} + {2'b00, inflight_q}) <
                    (3'd2 + {2'b00, w_pop})) begin
                    w_issue = 1'b1;
                    mem_ce  = 1'b1;
                    idx_d   = idx_q + 11'd1;
                    if (idx_q == (len_q - 11'd1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inflight_d = w_issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_gbuf_dma_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gbuf_dma_engine
// Purpose  : Self-checking bench for gbuf_dma_engine. A behavioural buffer
//            image (ref_mem) predicts every write address/data and every
//            streamed read word; stimulus validity/readiness is randomized.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gbuf_dma_engine;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [31:0]   cmd_base = '0;
    logic [10:0]   cmd_len = '0;
    logic          busy, done, err;
    logic          mem_ce, mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] mem     [1024];  // physical buffer attached to the DUT
    logic [DW-1:0] ref_mem [1024];  // expected buffer contents
    logic [DW-1:0] wbuf    [1024];  // words to stream in for a write

    always #5 clk = ~clk;

    gbuf_dma_engine #(.DATA_W(DW), .DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .busy(busy), .done(done), .err(err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic issue_cmd(input bit dir, input int base, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_base  = ($urandom() & 32'hFFFF_FC00) | 32'(base);
        cmd_len   = 11'(len);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || mem_ce !== 1'b0) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b mem_ce=%b, want 1/0", cmd_ready, mem_ce);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input int base, input int len, input bit rnd);
        int i;
        int cyc;
        issue_cmd(1'b1, base, len);
        i = 0;
        cyc = 0;
        while (i < len && cyc < 8 * len + 20) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = wbuf[i];
            #1;
            vectors++;
            if (in_ready !== 1'b1 || mem_ce !== in_valid || mem_we !== in_valid || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_ctrl: in_ready=%b mem_ce=%b mem_we=%b out_valid=%b, want 1/%b/%b/0",
                         in_ready, mem_ce, mem_we, out_valid, in_valid, in_valid);
            end
            if (in_valid) begin
                vectors++;
                if (mem_addr !== 32'((base + i) % 1024) || mem_wdata !== wbuf[i]) begin
                    errors++;
                    $display("FAIL wr_addr_data: word %0d got addr=%h data=%h, want addr=%h data=%h",
                             i, mem_addr, mem_wdata, (base + i) % 1024, wbuf[i]);
                end
                ref_mem[(base + i) % 1024] = wbuf[i];
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (i != len) begin
            errors++;
            $display("FAIL wr_timeout: got %0d handshakes, want %0d", i, len);
        end
        #1;
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || mem_ce !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: done=%b err=%b busy=%b mem_ce=%b in_ready=%b, want 1/0/1/0/0",
                     done, err, busy, mem_ce, in_ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle: done=%b cmd_ready=%b busy=%b, want 0/1/0", done, cmd_ready, busy);
        end
    endtask

    // mode 0: out_ready always 1 (timing checked), 1: 1,0,0 pattern, 2: random
    task automatic run_read(input int base, input int len, input int mode);
        int issued;
        int delivered;
        int cyc;
        bit fin;
        bit stall_prev;
        logic [DW-1:0] prev;
        issue_cmd(1'b0, base, len);
        issued = 0;
        delivered = 0;
        cyc = 1;
        fin = 1'b0;
        stall_prev = 1'b0;
        prev = '0;
        while (!fin && cyc < 6 * len + 20) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'((cyc % 3) == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (done === 1'b1) begin
                fin = 1'b1;
                vectors++;
                if (err !== 1'b0 || out_valid !== 1'b0 || mem_ce !== 1'b0 || issued != len || delivered != len) begin
                    errors++;
                    $display("FAIL rd_done: err=%b out_valid=%b mem_ce=%b issued=%0d delivered=%0d, want 0/0/0/%0d/%0d",
                             err, out_valid, mem_ce, issued, delivered, len, len);
                end
            end else begin
                vectors++;
                if (in_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_ctrl: in_ready=%b mem_we=%b busy=%b, want 0/0/1", in_ready, mem_we, busy);
                end
                if (mem_ce === 1'b1) begin
                    vectors++;
                    if (issued >= len || mem_addr !== 32'((base + issued) % 1024)) begin
                        errors++;
                        $display("FAIL rd_addr: read %0d got addr=%h, want addr=%h (len %0d)",
                                 issued, mem_addr, (base + issued) % 1024, len);
                    end
                    issued++;
                end
                if (stall_prev) begin
                    vectors++;
                    if (out_valid !== 1'b1 || out_data !== prev) begin
                        errors++;
                        $display("FAIL rd_hold: out_valid=%b out_data=%h, want 1/%h", out_valid, out_data, prev);
                    end
                end
                if (mode == 0) begin
                    vectors++;
                    if (out_valid !== 1'(cyc >= 2 && cyc <= len + 1)) begin
                        errors++;
                        $display("FAIL rd_stream_timing: cycle %0d out_valid=%b, want %b",
                                 cyc, out_valid, (cyc >= 2 && cyc <= len + 1));
                    end
                end
                if (out_valid === 1'b1 && out_ready) begin
                    vectors++;
                    if (delivered >= len || out_data !== ref_mem[(base + delivered) % 1024]) begin
                        errors++;
                        $display("FAIL rd_data: word %0d got %h, want %h", delivered, out_data,
                                 ref_mem[(base + delivered) % 1024]);
                    end
                    delivered++;
                end
                stall_prev = (out_valid === 1'b1) && !out_ready;
                prev = out_data;
                vectors++;
                if (issued - delivered > 2) begin
                    errors++;
                    $display("FAIL rd_outstanding: got %0d reads outstanding+buffered, want <= 2",
                             issued - delivered);
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (!fin) begin
            errors++;
            $display("FAIL rd_timeout: got no done, want done (delivered %0d of %0d)", delivered, len);
        end
    endtask

    task automatic fill_wbuf(input int len);
        for (int i = 0; i < len; i++) wbuf[i] = DW'($urandom());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            out_valid !== 1'b0 || mem_ce !== 1'b0 || mem_we !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cmd_ready=%b busy=%b done=%b err=%b out_valid=%b mem_ce=%b mem_we=%b in_ready=%b, want 1/0/0/0/0/0/0/0",
                     cmd_ready, busy, done, err, out_valid, mem_ce, mem_we, in_ready);
        end
    endtask

    task automatic test_write();
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(16'hA1 + i);
        run_write(32'h010, 4, 1'b0);
    endtask

    task automatic test_stream_read();
        run_read(32'h010, 4, 0);
    endtask

    task automatic test_backpressure();
        fill_wbuf(8);
        run_write(32'h100, 8, 1'b1);
        run_read(32'h100, 8, 1);
    endtask

    task automatic test_wrap();
        fill_wbuf(4);
        run_write(32'h3FE, 4, 1'b1);
        run_read(32'h3FE, 4, 0);
        run_read(32'h3FE, 4, 2);
    endtask

    task automatic test_illegal_len();
        int lens[3] = '{0, 1025, 2047};
        for (int k = 0; k < 3; k++) begin
            issue_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), lens[k]);
            #1;
            vectors++;
            if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b1 || mem_ce !== 1'b0 ||
                out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL illegal_done_err: len %0d done=%b err=%b busy=%b mem_ce=%b out_valid=%b in_ready=%b, want 1/1/1/0/0/0",
                         lens[k], done, err, busy, mem_ce, out_valid, in_ready);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1 || mem_ce !== 1'b0) begin
                errors++;
                $display("FAIL illegal_idle: done=%b err=%b cmd_ready=%b mem_ce=%b, want 0/0/1/0",
                         done, err, cmd_ready, mem_ce);
            end
        end
    endtask

    task automatic test_mid_reset();
        int delivered;
        int cyc;
        fill_wbuf(8);
        run_write(32'h200, 8, 1'b0);
        issue_cmd(1'b0, 32'h200, 8);
        delivered = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (delivered < 3 && cyc < 40) begin
            #1;
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_data !== ref_mem[32'h200 + delivered]) begin
                    errors++;
                    $display("FAIL mid_rst_data: word %0d got %h, want %h", delivered, out_data,
                             ref_mem[32'h200 + delivered]);
                end
                delivered++;
            end
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_idle: busy=%b cmd_ready=%b out_valid=%b, want 0/1/0", busy, cmd_ready, out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0 || mem_ce !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_quiet: out_valid=%b mem_ce=%b busy=%b, want 0/0/0", out_valid, mem_ce, busy);
            end
        end
        out_ready = 1'b0;
        run_read(32'h200, 8, 0);
        fill_wbuf(5);
        run_write(32'h205, 5, 1'b1);
        run_read(32'h203, 6, 2);
    endtask

    task automatic test_full_length();
        int b;
        b = int'($urandom_range(0, 1023));
        fill_wbuf(1024);
        run_write(b, 1024, 1'b0);
        run_read(b, 1024, 2);
        fill_wbuf(1);
        b = int'($urandom_range(0, 1023));
        run_write(b, 1, 1'b1);
        run_read(b, 1, 0);
    endtask

    task automatic test_back_to_back();
        int b;
        int l;
        for (int k = 0; k < 12; k++) begin
            b = int'($urandom_range(0, 1023));
            l = int'($urandom_range(1, 48));
            if ($urandom_range(0, 1) == 1) begin
                fill_wbuf(l);
                run_write(b, l, 1'b1);
            end else begin
                run_read(b, l, 2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = DW'($urandom());
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write();
        test_stream_read();
        test_backpressure();
        test_wrap();
        test_illegal_len();
        test_mid_reset();
        test_full_length();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gbuf_dma_engine.md
GBUF_DMA_ENGINE -- requirements
Module: gbuf_dma_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning word width of the buffer and stream data.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning buffer words; address wraps modulo DEPTH.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_dir  input  1  0 = buffer-to-stream read, 1 = stream-to-buffer write.
REQ-008 SHALL have port cmd_base  input  32  start word address; only bits [9:0] used.
REQ-009 SHALL have port cmd_len  input  11  word count; legal range 1..1024.
REQ-010 SHALL have port busy  output  1  command in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at command completion.
REQ-012 SHALL have port err  output  1  one-cycle pulse, coincident with done, for an illegal cmd_len.
REQ-013 SHALL have ports mem_ce, mem_we (output, 1 each), mem_addr (output, 32), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W), meaning a global-buffer master port; read data is valid on the cycle after mem_ce && !mem_we.
REQ-014 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W), meaning the write-direction stream.
REQ-015 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATA_W), meaning the read-direction stream.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, DRAIN and DONE.
REQ-017 SHALL assert cmd_ready only in IDLE; on accept, latch base[9:0], len and dir.
REQ-018 SHALL treat cmd_len == 0 or cmd_len > 1024 as illegal: go IDLE->DONE, assert err and done for one cycle, and perform no memory or stream activity.
REQ-019 SHALL, on accept of a legal command, go to WRITE if dir == 1 and to READ if dir == 0.
REQ-020 SHALL form word address as (base + idx) mod 1024, where idx counts 0..len-1; mem_addr[31:10] SHALL be 0.
REQ-021 SHALL, in WRITE, drive in_ready = 1 and combinationally drive mem_ce = mem_we = in_valid, with mem_wdata = in_data and mem_addr at the current idx.
REQ-022 SHALL, in WRITE, increment idx per in handshake; the handshake for word len-1 SHALL move the FSM to DONE on the next cycle.
REQ-023 SHALL, in READ, issue a read (mem_ce = 1, mem_we = 0) when the output FIFO count plus in-flight reads, minus any pop this cycle, is < 2.
REQ-024 SHALL push mem_rdata into a 2-entry output FIFO on the cycle after each issued read.
REQ-025 SHALL drive out_valid = FIFO non-empty and out_data = FIFO head, and pop on out_valid && out_ready.
REQ-026 SHALL sustain 1 word/cycle with out_ready held high; first out_valid SHALL come 2 cycles after command accept.
REQ-027 SHALL move READ->DRAIN after issuing read len-1, and DRAIN->DONE when the FIFO is empty and no read is in flight.
REQ-028 SHALL hold out_data stable while out_valid && !out_ready, and never drop or duplicate a word.
REQ-029 SHALL stay in DONE exactly one cycle with done = 1, then return to IDLE; busy = 1 in all states except IDLE.
REQ-030 SHALL hold mem_ce = mem_we = 0 in IDLE, DRAIN and DONE, and drive in_ready = 0 outside WRITE.
REQ-031 SHALL wrap from address 1023 to 0 with no gap or stall.

Reset
REQ-032 SHALL, on rst = 1 at a clock edge, enter IDLE, clear idx, FIFO and in-flight state, and drive busy = done = err = out_valid = mem_ce = mem_we = in_ready = 0 and cmd_ready = 1 the cycle after.
REQ-033 SHALL discard any mem_rdata returning after a reset taken mid-READ; no out_valid from the aborted command.

Verification
REQ-034 SHALL verify write: dir = 1, base = 0x010, len = 4, in_data 0xA1..0xA4 with in_valid held high -> 4 consecutive writes to addresses 0x010..0x013, then done one cycle later.
REQ-035 SHALL verify streaming read: read back the data from REQ-034 with out_ready high -> out_data 0xA1..0xA4 on 4 consecutive cycles starting 2 cycles after accept, then done.
REQ-036 SHALL verify backpressure: read len = 8 with out_ready toggling 1,0,0,1,... -> all 8 words delivered in order and never more than 2 reads outstanding plus buffered.
REQ-037 SHALL verify wrap: write then read base = 0x3FE, len = 4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 and data intact.
REQ-038 SHALL verify illegal length: cmd_len = 0 and cmd_len = 1025 -> done and err pulse together, with zero mem_ce.
REQ-039 SHALL verify mid-op reset: rst asserted at READ word 3 of 8 -> IDLE next cycle, no further out_valid, and the next command runs correctly.
